// File: rtl/adder_tree_pkg.sv
// ============================================================================
//  Module      : adder_tree_pkg
//  Description : Shared helpers for the adder-tree accumulator (sizing,
//                round-half-to-even, saturating clip).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_tree_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int acc_width(input int data_width, input int num_inputs,
                                     input int acc_guard);
        return data_width + clog2(num_inputs) + acc_guard;
    endfunction

    // Adding (half - 1) plus the LSB that survives the shift breaks ties toward even.
    function automatic logic signed [63:0] round_half_even(input logic signed [63:0] a,
                                                           input int shift);
        logic signed [63:0] r;
        logic [5:0]         s;
        if (shift == 0) return a;
        s = shift[5:0];
        r = a + ((64'sd1 <<< (shift - 1)) - 64'sd1) + {63'd0, a[s]};
        return r >>> shift;
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] a,
                                                    input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_tree_level.sv
// ============================================================================
//  Module      : adder_tree_level
//  Description : One registered level of the reduction tree: N operands are
//                summed pairwise into N/2 results, valid/last ride alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_level #(
    parameter int N     = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [N*WIDTH-1:0]         in_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [(N/2)*WIDTH-1:0]     out_data
);

    logic [(N/2)*WIDTH-1:0] w_sum;

    for (genvar i = 0; i < N / 2; i++) begin : g_pair
        assign w_sum[i*WIDTH +: WIDTH] = in_data[(2*i)*WIDTH +: WIDTH]
                                       + in_data[(2*i+1)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_last  <= in_valid & in_last;
            if (in_valid) out_data <= w_sum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_tree_acc.sv
// ============================================================================
//  Module      : adder_tree_acc
//  Description : Pipelined signed adder tree with multi-beat accumulation,
//                round-half-to-even, shift and clip. Define ADDER_TREE_SAT_EN
//                for saturating output; otherwise the result wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_INPUTS = 32,
    parameter int OUT_SHIFT  = 5,
    parameter int ACC_GUARD  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             data_valid_in,
    input  logic                             last_in,
    input  logic                             end_flag,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_numbers,
    output logic [DATA_WIDTH-1:0]            sum_output,
    output logic                             data_valid_out,
    output logic                             sat_flag,
    output logic                             beat_err
);

    localparam int LEVELS    = clog2(NUM_INPUTS);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, NUM_INPUTS, ACC_GUARD);
    localparam int TREE_OPS  = 2 * NUM_INPUTS - 1;
    localparam int CNT_MAX_I = 1 << ACC_GUARD;
    localparam logic [ACC_GUARD:0] CNT_MAX = CNT_MAX_I[ACC_GUARD:0];

    // Stage 0 capture
    logic [NUM_INPUTS*DATA_WIDTH-1:0] r_s0_data;
    logic                             r_s0_valid;
    logic                             r_s0_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_data  <= '0;
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else if (end_flag) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
        end else begin
            r_s0_valid <= data_valid_in;
            r_s0_last  <= data_valid_in & last_in;
            if (data_valid_in) r_s0_data <= input_numbers;
        end
    end

    // All tree levels packed back to back: level l starts at operand 2N - 2*(N>>l).
    logic [TREE_OPS*ACC_WIDTH-1:0] w_tree;
    logic [LEVELS:0]               w_lvl_valid;
    logic [LEVELS:0]               w_lvl_last;

    assign w_lvl_valid[0] = r_s0_valid;
    assign w_lvl_last[0]  = r_s0_last;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_sext
        assign w_tree[k*ACC_WIDTH +: ACC_WIDTH] =
            {{(ACC_WIDTH-DATA_WIDTH){r_s0_data[k*DATA_WIDTH+DATA_WIDTH-1]}},
             r_s0_data[k*DATA_WIDTH +: DATA_WIDTH]};
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int N_IN    = NUM_INPUTS >> l;
        localparam int OFF_IN  = 2 * NUM_INPUTS - 2 * N_IN;
        localparam int OFF_OUT = 2 * NUM_INPUTS - N_IN;

        adder_tree_level #(
            .N     (N_IN),
            .WIDTH (ACC_WIDTH)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .flush     (end_flag),
            .in_valid  (w_lvl_valid[l]),
            .in_last   (w_lvl_last[l]),
            .in_data   (w_tree[OFF_IN*ACC_WIDTH +: N_IN*ACC_WIDTH]),
            .out_valid (w_lvl_valid[l+1]),
            .out_last  (w_lvl_last[l+1]),
            .out_data  (w_tree[OFF_OUT*ACC_WIDTH +: (N_IN/2)*ACC_WIDTH])
        );
    end

    logic signed [ACC_WIDTH-1:0] w_tree_sum;
    assign w_tree_sum = $signed(w_tree[(TREE_OPS-1)*ACC_WIDTH +: ACC_WIDTH]);

    // Accumulator; a zero beat count marks the first beat of a new result.
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [ACC_GUARD:0]          r_beat_cnt;
    logic                        r_res_valid;
    logic                        w_beat_valid;
    logic                        w_beat_last;

    assign w_beat_valid = w_lvl_valid[LEVELS];
    assign w_beat_last  = w_lvl_last[LEVELS];

    always_ff @(posedge clk) begin
        if (reset || end_flag) begin
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_res_valid <= 1'b0;
            beat_err    <= 1'b0;
        end else begin
            r_res_valid <= w_beat_valid & w_beat_last;
            if (w_beat_valid) begin
                r_acc <= ((r_beat_cnt == '0) ? '0 : r_acc) + w_tree_sum;
                if (w_beat_last)
                    r_beat_cnt <= '0;
                else if (r_beat_cnt != CNT_MAX)
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                if (!w_beat_last && (r_beat_cnt == CNT_MAX))
                    beat_err <= 1'b1;
            end
        end
    end

    logic signed [63:0]    w_rounded;
    logic [DATA_WIDTH-1:0] w_y;
    logic                  w_sat;

    assign w_rounded = round_half_even({{(64-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc},
                                       OUT_SHIFT);

`ifdef ADDER_TREE_SAT_EN
    assign w_y   = DATA_WIDTH'(sat_clip(w_rounded, DATA_WIDTH));
    assign w_sat = (sat_clip(w_rounded, DATA_WIDTH) != w_rounded);
`else
    assign w_y   = DATA_WIDTH'(w_rounded);
    assign w_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_output     <= '0;
            data_valid_out <= 1'b0;
            sat_flag       <= 1'b0;
        end else if (end_flag) begin
            data_valid_out <= 1'b0;
            sat_flag       <= 1'b0;
        end else begin
            data_valid_out <= r_res_valid;
            sat_flag       <= r_res_valid & w_sat;
            if (r_res_valid) sum_output <= w_y;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_tree_acc.sv
// ============================================================================
//  Module      : tb_adder_tree_acc
//  Description : Directed self-checking bench for adder_tree_acc.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_tree_acc;

    localparam int DW = 12;
    localparam int NI = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               data_valid_in;
    logic               last_in;
    logic               end_flag;
    logic [NI*DW-1:0]   input_numbers;
    logic [DW-1:0]      sum_output;
    logic               data_valid_out;
    logic               sat_flag;
    logic               beat_err;

    adder_tree_acc #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .OUT_SHIFT  (5),
        .ACC_GUARD  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_valid_in  (data_valid_in),
        .last_in        (last_in),
        .end_flag       (end_flag),
        .input_numbers  (input_numbers),
        .sum_output     (sum_output),
        .data_valid_out (data_valid_out),
        .sat_flag       (sat_flag),
        .beat_err       (beat_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] q_sum[$];
    logic          q_sat[$];
    int            q_cyc[$];

    always @(negedge clk) begin
        if (data_valid_out === 1'b1) begin
            q_sum.push_back(sum_output);
            q_sat.push_back(sat_flag);
            q_cyc.push_back(cyc);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic e,
                         input int val, input int n, output int t);
        @(negedge clk);
        data_valid_in = v;
        last_in       = l;
        end_flag      = e;
        input_numbers = '0;
        for (int k = 0; k < n; k++) input_numbers[k*DW +: DW] = val[DW-1:0];
        t = cyc;
    endtask

    task automatic idle(input int n);
        int t;
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0, t);
    endtask

    task automatic expect_res(input string tag, input int exp_val, input int exp_sat,
                              input int exp_cyc);
        logic [DW-1:0] s;
        logic          f;
        int            c;
        if (q_sum.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            s = q_sum.pop_front();
            f = q_sat.pop_front();
            c = q_cyc.pop_front();
            check(tag, int'($signed(s)), exp_val);
            check({tag, "_sat"}, int'(f), exp_sat);
            check({tag, "_cycle"}, c, exp_cyc);
        end
    endtask

    task automatic clear_q();
        q_sum.delete();
        q_sat.delete();
        q_cyc.delete();
    endtask

    int t0, t1, t2, t3, exp_big, exp_big_sat;

    initial begin
        reset         = 1'b1;
        data_valid_in = 1'b0;
        last_in       = 1'b0;
        end_flag      = 1'b0;
        input_numbers = '0;
        repeat (3) @(negedge clk);
        check("rst_sum",   int'(sum_output),     0);
        check("rst_valid", int'(data_valid_out), 0);
        check("rst_sat",   int'(sat_flag),       0);
        check("rst_err",   int'(beat_err),       0);
        reset = 1'b0;
        idle(2);
        clear_q();

        // 32 x 1 = 32 -> 1.0
        drive(1'b1, 1'b1, 1'b0, 1, 32, t0);
        idle(12);
        check("t1_count", q_sum.size(), 1);
        expect_res("t1", 1, 0, t0 + 8);

        // 48 -> 1.5 -> 2, 80 -> 2.5 -> 2, -32 -> -1
        drive(1'b1, 1'b1, 1'b0, 3, 16, t0);
        drive(1'b1, 1'b1, 1'b0, 5, 16, t1);
        drive(1'b1, 1'b1, 1'b0, -1, 32, t2);
        idle(12);
        check("t2_count", q_sum.size(), 3);
        expect_res("t2_1p5", 2, 0, t0 + 8);
        expect_res("t2_2p5", 2, 0, t1 + 8);
        expect_res("t2_neg", -1, 0, t2 + 8);

        // 4 x 65504 = 262016 -> 8188, out of 12-bit range
`ifdef ADDER_TREE_SAT_EN
        exp_big     = 2047;
        exp_big_sat = 1;
`else
        exp_big     = -4;
        exp_big_sat = 0;
`endif
        drive(1'b1, 1'b0, 1'b0, 2047, 32, t0);
        drive(1'b1, 1'b0, 1'b0, 2047, 32, t0);
        drive(1'b1, 1'b0, 1'b0, 2047, 32, t0);
        drive(1'b1, 1'b1, 1'b0, 2047, 32, t0);
        idle(12);
        check("t3_count", q_sum.size(), 1);
        expect_res("t3_big", exp_big, exp_big_sat, t0 + 8);

        // Aborted beats plus a same-cycle valid beat are all discarded
        drive(1'b1, 1'b0, 1'b0, 1, 32, t0);
        drive(1'b1, 1'b0, 1'b0, 1, 32, t0);
        drive(1'b1, 1'b1, 1'b1, 7, 32, t0);
        drive(1'b1, 1'b1, 1'b0, 2, 32, t1);
        idle(12);
        check("t4_count", q_sum.size(), 1);
        expect_res("t4_abort", 2, 0, t1 + 8);

        // Back-to-back single-beat results
        drive(1'b1, 1'b1, 1'b0, 1, 32, t0);
        drive(1'b1, 1'b1, 1'b0, 2, 32, t1);
        drive(1'b1, 1'b1, 1'b0, 3, 32, t2);
        idle(12);
        check("t5_count", q_sum.size(), 3);
        expect_res("t5_a", 1, 0, t0 + 8);
        expect_res("t5_b", 2, 0, t1 + 8);
        expect_res("t5_c", 3, 0, t2 + 8);

        // Beat counter overflow
        for (int b = 0; b < 16; b++) drive(1'b1, 1'b0, 1'b0, 1, 32, t3);
        idle(10);
        check("t6_err_16", int'(beat_err), 0);
        drive(1'b1, 1'b0, 1'b0, 1, 32, t3);
        idle(10);
        check("t6_err_17", int'(beat_err), 1);
        drive(1'b0, 1'b0, 1'b1, 0, 0, t3);
        idle(2);
        check("t6_err_clr", int'(beat_err), 0);
        check("t6_no_out", q_sum.size(), 0);
        check("t6_hold", int'(sum_output), 3);

        // Reset while a result is in flight
        drive(1'b1, 1'b1, 1'b0, 1, 32, t3);
        idle(3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_sum",   int'(sum_output),     0);
        check("t6_rst_valid", int'(data_valid_out), 0);
        check("t6_rst_err",   int'(beat_err),       0);
        reset = 1'b0;
        idle(12);
        check("t6_rst_no_out", q_sum.size(), 0);
        check("t6_rst_hold",   int'(sum_output), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
